regfile_display_ctrl: RTL and testbench
=======================================

// Module: regfile_display_ctrl
// PURPOSE
//  Debug-display controller for the pipeline core. Shares register-file read port 2 (rs2) with the
//  decode stage: steals idle read slots, and requests a one-cycle stall when starved. Captures the
//  register chosen by sel, converts it to hex or decimal, and drives four 7-seg digits and LED_out.
//  Sits in the top level beside the register file; the pipeline keeps priority on the port.
// PARAMETERS
//  REFRESH_CYCLES  50_000  cycles between automatic re-reads of the selected register (>=32)
//  STARVE_LIMIT    8       cycles waiting for a free rs2 slot before stall_req is raised (>=1)
// PORTS
//  clk50          in   1   system clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  sel            in   5   register index to display (x0..x31)
//  mode_dec       in   1   1 = unsigned decimal of rdata[15:0], 0 = hex of rdata[15:0]
//  pipe_rs2_used  in   1   decode stage needs read port 2 this cycle
//  rdata          in   32  read-port-2 data, combinational from the regfile address
//  dbg_rsel       out  1   1 = regfile port-2 address mux takes dbg_raddr this cycle
//  dbg_raddr      out  5   debug read address (registered copy of sel)
//  stall_req      out  1   request to the hazard unit to freeze decode for a free rs2 slot
//  seg1..seg4     out  7   active-low {g,f,e,d,c,b,a}; seg1 = least significant digit
//  LED_out        out  9   [4:0] displayed index, [5] mode of shown value, [6] busy, [7] overflow, [8] stall seen
// BEHAVIOUR
//  Reset: state IDLE, refresh timer 0, dbg_rsel=0, stall_req=0, dbg_raddr=0, segs all 7'h7F (blank),
//   LED_out=0. Reset mid-operation abandons any conversion; no partial value reaches the display.
//  FSM: IDLE -> WAIT_PORT -> (CONVERT) -> SHOW -> IDLE.
//   IDLE: go to WAIT_PORT when timer hits REFRESH_CYCLES-1, or one cycle after sel or mode_dec changes
//    (both inputs are registered; a change takes priority over the timer; timer clears on entry).
//    dbg_raddr and the mode copy are latched on entry.
//   WAIT_PORT: dbg_rsel = !pipe_rs2_used (combinational). On the cycle dbg_rsel=1, capture rdata[15:0]
//    on that edge. Then go to CONVERT if mode is decimal, otherwise to SHOW.
//    A wait counter increments each cycle with pipe_rs2_used=1. When the count reaches STARVE_LIMIT,
//    stall_req goes 1 (registered) and stays 1 until the capture edge, then clears the next cycle.
//    While stall_req=1 the pipeline must drop pipe_rs2_used within one cycle. LED_out[8] sets and holds
//    until reset.
//   CONVERT: sequential double-dabble, 16 shift cycles. Values >9999 set overflow.
//   SHOW: one cycle; segs, LED_out[7:0] update atomically; back to IDLE.
//  Latency: capture edge -> display = 1 cycle (hex), 17 cycles (decimal).
//  sel/mode change during WAIT_PORT or CONVERT: finish the current value, then re-run immediately from
//   IDLE (pending flag).
//  x0 is read through the port like any other register; no special case.
//  Hex mode: digit n = nibble n-1 of the 16-bit value; overflow=0.
//  Decimal overflow: all four digits show dash 7'b0111111, LED_out[7]=1.
//  Simultaneous timer expiry and sel change give a single read.
//  LED_out[6] = (state != IDLE).
// STRUCTURE
//  Package regdisp_pkg: state enum (IDLE, WAIT_PORT, CONVERT, SHOW), SEG_HEX[16] active-low table,
//   SEG_DASH, SEG_BLANK constants.
//  Sub-module bin2bcd_seq: start/busy/done, 16-bit in, 16-bit BCD out, overflow flag; async active-high rst.
//  Top level: FSM, timer, starve counter, seg encode registers.
// TESTING
//  1 x5=0x00001234, hex, pipe_rs2_used=0 -> seg4..seg1 = 1,2,3,4 (1111001,0100100,0110000,0011001),
//    LED_out[4:0]=5.
//  2 x3=0x000004D2, mode_dec=1 -> dbg_rsel pulse, then 17 cycles later digits 1,2,3,4, LED_out[7]=0.
//  3 x7=0x00003039 (12345), decimal -> all segs 0111111, LED_out[7]=1.
//  4 pipe_rs2_used held 1, STARVE_LIMIT=8 -> stall_req rises after 8 wait cycles. Drop pipe_rs2_used ->
//    dbg_rsel=1 that cycle, stall_req low next cycle, LED_out[8]=1.
//  5 sel 1->2 during CONVERT -> x1 shown first, then immediate re-read shows x2 with no refresh wait.
//  6 rst asserted mid-CONVERT -> outputs blank and LED_out=0 at once; after release, next read
//    completes normally.

Source files
------------

// File: rtl/regdisp_pkg.sv
// Shared state type and active-low 7-segment constants ({g,f,e,d,c,b,a})
// for the register-file debug display.
package regdisp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PORT,
        CONVERT,
        SHOW
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to four BCD digits in 16 shift cycles,
// with a flag for values that need a fifth digit (>9999).
module bin2bcd_seq (
    input  logic        clk50,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    logic [3:0]  cnt;
    logic [15:0] bin_p0;
    logic [19:0] acc_p0;

    function automatic logic [19:0] add3(input logic [19:0] a);
        logic [19:0] r;
        for (int i = 0; i < 5; i++)
            r[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
        return r;
    endfunction

    // done marks the final shift; the result is stable from the following cycle
    assign done = busy && (cnt == 4'd15);
    assign bcd  = acc_p0[15:0];
    assign ovf  = |acc_p0[19:16];

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 4'd1;
            if (done)
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk50) begin
        if (start) begin
            bin_p0 <= din;
            acc_p0 <= '0;
        end else if (busy) begin
            {acc_p0, bin_p0} <= {add3(acc_p0), bin_p0} << 1;
        end
    end

endmodule

// File: rtl/regfile_display_ctrl.sv
// Debug display controller: steals idle rs2 read slots to fetch the selected register
// and shows its low half as hex or decimal on four 7-segment digits plus status LEDs.
module regfile_display_ctrl
    import regdisp_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50_000,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic [4:0]  sel,
    input  logic        mode_dec,
    input  logic        pipe_rs2_used,
    input  logic [31:0] rdata,
    output logic        dbg_rsel,
    output logic [4:0]  dbg_raddr,
    output logic        stall_req,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [6:0]  seg4,
    output logic [8:0]  LED_out
);

    localparam int TIMER_W  = $clog2(REFRESH_CYCLES);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    state_t              state, state_nxt;
    logic [4:0]          sel_s, sel_q;
    logic                mode_s, mode_q, mode_lat;
    logic                chg, pending, timer_hit, go, capture;
    logic [TIMER_W-1:0]  timer;
    logic [STARVE_W-1:0] wcnt;
    logic                stall_seen, ovf_disp, mode_disp;
    logic [4:0]          idx_disp;
    logic [15:0]         val_p0;
    logic                bcd_start, bcd_busy, bcd_done, bcd_ovf;
    logic [15:0]         bcd;
    logic                rdata_unused;

    function automatic logic [6:0] dec_seg(input logic [3:0] digit, input logic ovf);
        return ovf ? SEG_DASH : hex_seg(digit);
    endfunction

    assign rdata_unused = ^rdata[31:16];
    assign chg          = (sel_s != sel_q) || (mode_s != mode_q);
    assign timer_hit    = (timer == TIMER_W'(REFRESH_CYCLES - 1));
    assign bcd_start    = capture && mode_lat;
    assign LED_out      = {stall_seen, ovf_disp, state != IDLE, mode_disp, idx_disp};

    bin2bcd_seq u_bcd (
        .clk50 (clk50),
        .rst   (rst),
        .start (bcd_start),
        .din   (rdata[15:0]),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd),
        .ovf   (bcd_ovf)
    );

    always_comb begin
        state_nxt = state;
        dbg_rsel  = 1'b0;
        capture   = 1'b0;
        go        = 1'b0;
        case (state)
            IDLE: begin
                if (chg || pending || timer_hit) begin
                    go        = 1'b1;
                    state_nxt = WAIT_PORT;
                end
            end
            WAIT_PORT: begin
                // the pipeline keeps priority: only take the port when decode leaves it idle
                dbg_rsel = !pipe_rs2_used;
                if (!pipe_rs2_used) begin
                    capture   = 1'b1;
                    state_nxt = mode_lat ? CONVERT : SHOW;
                end
            end
            CONVERT: begin
                if (bcd_done || !bcd_busy)
                    state_nxt = SHOW;
            end
            SHOW:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_s      <= '0;
            sel_q      <= '0;
            mode_s     <= 1'b0;
            mode_q     <= 1'b0;
            pending    <= 1'b0;
            timer      <= '0;
            wcnt       <= '0;
            stall_req  <= 1'b0;
            stall_seen <= 1'b0;
            dbg_raddr  <= '0;
            mode_lat   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel_s  <= sel;
            sel_q  <= sel_s;
            mode_s <= mode_dec;
            mode_q <= mode_s;

            // a change seen while busy re-runs the read as soon as we are back in IDLE
            if (go)
                pending <= 1'b0;
            else if (chg)
                pending <= 1'b1;

            timer <= (state == IDLE && !go) ? timer + TIMER_W'(1) : '0;

            if (go) begin
                dbg_raddr <= sel_s;
                mode_lat  <= mode_s;
            end

            if (go)
                wcnt <= '0;
            else if (state == WAIT_PORT && pipe_rs2_used && wcnt != STARVE_W'(STARVE_LIMIT))
                wcnt <= wcnt + STARVE_W'(1);

            if (capture) begin
                stall_req <= 1'b0;
            end else if (state == WAIT_PORT && pipe_rs2_used &&
                         wcnt == STARVE_W'(STARVE_LIMIT - 1)) begin
                stall_req  <= 1'b1;
                stall_seen <= 1'b1;
            end
        end
    end

    // display stage: digits and status LEDs change together on the SHOW edge only
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            seg1      <= SEG_BLANK;
            seg2      <= SEG_BLANK;
            seg3      <= SEG_BLANK;
            seg4      <= SEG_BLANK;
            ovf_disp  <= 1'b0;
            mode_disp <= 1'b0;
            idx_disp  <= '0;
        end else if (state == SHOW) begin
            if (mode_lat) begin
                seg1 <= dec_seg(bcd[3:0],   bcd_ovf);
                seg2 <= dec_seg(bcd[7:4],   bcd_ovf);
                seg3 <= dec_seg(bcd[11:8],  bcd_ovf);
                seg4 <= dec_seg(bcd[15:12], bcd_ovf);
            end else begin
                seg1 <= hex_seg(val_p0[3:0]);
                seg2 <= hex_seg(val_p0[7:4]);
                seg3 <= hex_seg(val_p0[11:8]);
                seg4 <= hex_seg(val_p0[15:12]);
            end
            ovf_disp  <= mode_lat && bcd_ovf;
            mode_disp <= mode_lat;
            idx_disp  <= dbg_raddr;
        end
    end

    // capture stage: data register, no reset needed
    always_ff @(posedge clk50) begin
        if (capture)
            val_p0 <= rdata[15:0];
    end

endmodule

// File: tb/tb_regfile_display_ctrl.sv
// Bench for regfile_display_ctrl: models the shared rs2 port and a register file,
// scoreboards every display update against a behavioural model of the display.
module tb_regfile_display_ctrl;

    localparam int REFRESH = 64;
    localparam int STARVE  = 8;

    typedef struct packed {
        logic [27:0] segs;
        logic [7:0]  led;
        logic [7:0]  lat;
    } exp_t;

    logic        clk50 = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  sel = '0;
    logic        mode_dec = 1'b0;
    logic        pipe_rs2_used = 1'b0;
    logic [31:0] rdata;
    logic        dbg_rsel;
    logic [4:0]  dbg_raddr;
    logic        stall_req;
    logic [6:0]  seg1, seg2, seg3, seg4;
    logic [8:0]  LED_out;

    logic [31:0] regs [32];
    logic [31:0] junk = '0;
    exp_t        q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, cap_cyc = 0, last_show = 0;
    int          pipe_mode = 0;
    logic        prev_busy = 1'b0;
    logic [4:0]  cur_sel = '0;
    logic        cur_mode = 1'b0;

    regfile_display_ctrl #(.REFRESH_CYCLES(REFRESH), .STARVE_LIMIT(STARVE)) dut (
        .clk50(clk50), .rst(rst), .sel(sel), .mode_dec(mode_dec),
        .pipe_rs2_used(pipe_rs2_used), .rdata(rdata), .dbg_rsel(dbg_rsel),
        .dbg_raddr(dbg_raddr), .stall_req(stall_req), .seg1(seg1), .seg2(seg2),
        .seg3(seg3), .seg4(seg4), .LED_out(LED_out)
    );

    always #10 clk50 = ~clk50;

    // port-2 mux of the top level: the debug address only when dbg_rsel, else pipeline traffic
    assign rdata = dbg_rsel ? regs[dbg_raddr] : junk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] r, input logic [4:0] s, input logic m);
        exp_t e;
        int   v;
        int   dig[4];
        logic ovf;
        v   = int'(r[15:0]);
        ovf = m && (v > 9999);
        for (int i = 0; i < 4; i++)
            dig[i] = m ? (v / (10 ** i)) % 10 : (v >> (4 * i)) & 15;
        e.segs = ovf ? {4{7'b0111111}}
                     : {seg_of(dig[3]), seg_of(dig[2]), seg_of(dig[1]), seg_of(dig[0])};
        e.led  = {ovf, 1'b0, m, s};
        e.lat  = m ? 8'd17 : 8'd1;
        return e;
    endfunction

    function automatic logic [31:0] rand_reg();
        if ($urandom_range(0, 1) == 1)
            return $urandom;
        return {16'($urandom), 16'($urandom_range(0, 9999))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic issue(input logic [4:0] s, input logic m);
        logic mm;
        mm = m;
        if (s == cur_sel && m == cur_mode)
            mm = !m;
        q.push_back(model(regs[s], s, mm));
        sel      = s;
        mode_dec = mm;
        cur_sel  = s;
        cur_mode = mm;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk50);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d reads outstanding after %0d cycles", q.size(), budget);
            q.delete();
        end
        tick(1);
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!LED_out[6] && n < budget) begin
            @(negedge clk50);
            n++;
        end
        checks++;
        if (!LED_out[6]) begin
            errors++;
            $display("FAIL busy_timeout: busy=%0b after %0d cycles, expected 1", LED_out[6], budget);
        end
    endtask

    always @(posedge clk50) cyc++;

    // pipeline model: drives decode's use of rs2 and obeys stall_req immediately
    always @(posedge clk50) begin
        #1;
        junk = $urandom;
        case (pipe_mode)
            1:       pipe_rs2_used = !stall_req && ($urandom_range(0, 9) < 7);
            2:       pipe_rs2_used = 1'b1;
            default: pipe_rs2_used = 1'b0;
        endcase
    end

    // monitor: a display update is the busy LED falling back to IDLE
    always @(negedge clk50) begin
        exp_t e;
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (dbg_rsel)
                cap_cyc = cyc;
            if (prev_busy && !LED_out[6]) begin
                last_show = cyc;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_display: segs %07b_%07b_%07b_%07b, none expected",
                             seg4, seg3, seg2, seg1);
                end else begin
                    e = q.pop_front();
                    check("display_segs", 32'({seg4, seg3, seg2, seg1}), 32'(e.segs));
                    check("display_led", 32'(LED_out[7:0]), 32'(e.led));
                    check("display_latency", 32'(cyc - cap_cyc - 1), 32'(e.lat));
                end
            end
            prev_busy = LED_out[6];
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t;
        logic [4:0] s2;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[5] = 32'h0000_1234;
        regs[3] = 32'h0000_04D2;
        regs[7] = 32'h0000_3039;

        tick(3);
        check("rst_segs", 32'({seg4, seg3, seg2, seg1}), 32'({4{7'h7F}}));
        check("rst_led", 32'(LED_out), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_rsel", 32'(dbg_rsel), 32'd0);
        check("rst_raddr", 32'(dbg_raddr), 32'd0);
        rst = 1'b0;
        tick(2);

        // hex, decimal, decimal overflow
        issue(5'd5, 1'b0);
        drain(100);
        check("hex_seg4", 32'(seg4), 32'(7'b1111001));
        check("hex_seg3", 32'(seg3), 32'(7'b0100100));
        check("hex_seg2", 32'(seg2), 32'(7'b0110000));
        check("hex_seg1", 32'(seg1), 32'(7'b0011001));
        check("hex_index", 32'(LED_out[4:0]), 32'd5);
        issue(5'd3, 1'b1);
        drain(100);
        check("dec_ovf_led", 32'(LED_out[7]), 32'd0);
        issue(5'd7, 1'b1);
        drain(100);
        check("ovf_seg1", 32'(seg1), 32'(7'b0111111));
        check("ovf_led", 32'(LED_out[7]), 32'd1);

        // selection change during CONVERT re-runs immediately
        regs[1] = {16'($urandom), 16'($urandom_range(0, 9999))};
        regs[2] = {16'($urandom), 16'($urandom_range(0, 9999))};
        issue(5'd1, 1'b1);
        wait_busy(20);
        tick(5);
        issue(5'd2, 1'b1);
        drain(120);

        // starvation: decode holds the port until stall_req forces a free slot
        pipe_mode = 2;
        regs[12] = rand_reg();
        tick(1);
        issue(5'd12, 1'b0);
        n = 0;
        t = 0;
        while (t < 100) begin
            @(negedge clk50);
            t++;
            if (stall_req) break;
            if (LED_out[6]) n++;
        end
        check("starve_cycles", 32'(n), 32'(STARVE));
        pipe_mode = 0;
        @(posedge clk50);
        #2;
        check("starve_rsel", 32'(dbg_rsel), 32'd1);
        check("starve_stall_held", 32'(stall_req), 32'd1);
        check("starve_raddr", 32'(dbg_raddr), 32'd12);
        @(posedge clk50);
        #2;
        check("starve_stall_clear", 32'(stall_req), 32'd0);
        check("starve_seen", 32'(LED_out[8]), 32'd1);
        drain(50);

        // automatic refresh picks up a changed register without any input change
        regs[12] = rand_reg();
        q.push_back(model(regs[12], 5'd12, 1'b0));
        tick(40);
        check("refresh_not_early", 32'(q.size()), 32'd1);
        drain(80);

        // selection change landing on the timer-expiry cycle gives exactly one read
        while (cyc < last_show + 61) @(negedge clk50);
        @(posedge clk50);
        #1;
        regs[20] = rand_reg();
        issue(5'd20, 1'b0);
        drain(100);
        tick(20);

        // reset in the middle of a decimal conversion
        regs[9] = {16'($urandom), 16'($urandom_range(0, 9999))};
        sel = 5'd9;
        mode_dec = 1'b1;
        cur_sel = 5'd9;
        cur_mode = 1'b1;
        wait_busy(20);
        tick(8);
        rst = 1'b1;
        #1;
        check("midrst_segs", 32'({seg4, seg3, seg2, seg1}), 32'({4{7'h7F}}));
        check("midrst_led", 32'(LED_out), 32'd0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_rsel", 32'(dbg_rsel), 32'd0);
        tick(2);
        rst = 1'b0;
        q.push_back(model(regs[9], 5'd9, 1'b1));
        drain(100);

        // randomized reads with random decode traffic and occasional mid-read changes
        pipe_mode = 1;
        for (int k = 0; k < 40; k++) begin
            s2 = 5'($urandom_range(0, 31));
            regs[s2] = rand_reg();
            issue(s2, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                wait_busy(20);
                tick($urandom_range(1, 20));
                issue(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
            drain(300);
        end
        pipe_mode = 0;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
